// File: rtl/shift_result_stage_pkg.sv
// Shared ALU definitions used by the shift result stage.
//   alu_flags_t : packed flag nibble {of, sf, zf, cf}, cf in bit 0.
//   FLAG_*      : bit positions of each flag inside alu_flags_t.
//   alu_entry_t : buffered result entry {r, dst, flags, flag_we} at the
//                 default datapath widths; the stage re-declares the same
//                 layout locally so its width parameters can be overridden.
package shift_result_stage_pkg;

  localparam int ALU_WORD_WIDTH = 16;
  localparam int ALU_DST_WIDTH  = 3;

  localparam int FLAG_CF = 0;
  localparam int FLAG_ZF = 1;
  localparam int FLAG_SF = 2;
  localparam int FLAG_OF = 3;

  typedef struct packed {
    logic of;
    logic sf;
    logic zf;
    logic cf;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_WORD_WIDTH-1:0] r;
    logic [ALU_DST_WIDTH-1:0]  dst;
    alu_flags_t                flags;
    logic                      flag_we;
  } alu_entry_t;

endpackage

// File: rtl/shift_result_stage_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer on a flat vector.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o : upstream handshake; in_ready_o is registered
//   in_data_i               : upstream payload
//   out_valid_o/out_ready_i : downstream handshake for the head entry
//   out_data_o              : head payload, held stable while stalled
//   skid_valid_o            : second entry occupied
//   main_mark_o/skid_mark_o : bit MARK_BIT of the head / skid payload, so
//                             the owner can inspect one tag bit per entry
module skid_buffer #(
  parameter int WIDTH    = 8,
  parameter int MARK_BIT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             skid_valid_o,
  output logic             main_mark_o,
  output logic             skid_mark_o
);

  logic             main_valid_reg;
  logic [WIDTH-1:0] main_data_reg;
  logic             skid_valid_reg;
  logic [WIDTH-1:0] skid_data_reg;

  logic accept;
  logic transfer;

  // Ready depends on registered state only, never on out_ready_i.
  assign in_ready_o = !skid_valid_reg;
  assign accept     = in_valid_i && !skid_valid_reg;
  assign transfer   = main_valid_reg && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else if (skid_valid_reg) begin
      // Full: no accept is possible; drain skid into main on transfer.
      if (transfer) begin
        main_data_reg  <= skid_data_reg;
        skid_valid_reg <= 1'b0;
      end
    end else if (main_valid_reg) begin
      if (accept && transfer) begin
        main_data_reg <= in_data_i;
      end else if (accept) begin
        skid_data_reg  <= in_data_i;
        skid_valid_reg <= 1'b1;
      end else if (transfer) begin
        main_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      main_data_reg  <= in_data_i;
      main_valid_reg <= 1'b1;
    end
  end

  assign out_valid_o  = main_valid_reg;
  assign out_data_o   = main_data_reg;
  assign skid_valid_o = skid_valid_reg;
  assign main_mark_o  = main_data_reg[MARK_BIT];
  assign skid_mark_o  = skid_data_reg[MARK_BIT];

endmodule

// File: rtl/shift_result_stage.sv
// Result stage after the ALU left-shift unit: derives flags from the
// shifted result, buffers entries in a 2-entry skid buffer, owns the
// architectural carry register and flags pending flag writes.
//   clk_i, rst_i               : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o    : upstream handshake
//   r_i, cf_i, a_msb_i         : shifted result, shift carry-out, operand MSB
//   flag_we_i, dst_i           : flag-write enable, destination tag
//   out_valid_o / out_ready_i  : writeback handshake for the head entry
//   r_o, dst_o, flags_o, flag_we_o : head entry ({of,sf,zf,cf} flags)
//   carry_o                    : carry register feeding the shift unit
//   pending_flag_o             : some buffered entry will write the flags
module shift_result_stage
  import shift_result_stage_pkg::*;
#(
  parameter int WORD_WIDTH = ALU_WORD_WIDTH,
  parameter int DST_WIDTH  = ALU_DST_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WORD_WIDTH-1:0] r_i,
  input  logic                  cf_i,
  input  logic                  a_msb_i,
  input  logic                  flag_we_i,
  input  logic [DST_WIDTH-1:0]  dst_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WORD_WIDTH-1:0] r_o,
  output logic [DST_WIDTH-1:0]  dst_o,
  output logic [3:0]            flags_o,
  output logic                  flag_we_o,
  output logic                  carry_o,
  output logic                  pending_flag_o
);

  // Same layout as alu_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] r;
    logic [DST_WIDTH-1:0]  dst;
    alu_flags_t            flags;
    logic                  flag_we;
  } entry_t;

  alu_flags_t in_flags;
  entry_t     in_entry;
  entry_t     head_entry;
  logic       skid_valid;
  logic       head_flag_we;
  logic       skid_flag_we;
  logic       carry_reg;

  always_comb begin
    in_flags    = '0;
    in_flags.zf = (r_i == '0);
    in_flags.sf = r_i[WORD_WIDTH-1];
    // A left shift overflows when the sign bit changed.
    in_flags.of = a_msb_i ^ r_i[WORD_WIDTH-1];
    in_flags.cf = cf_i;
  end

  assign in_entry = '{r: r_i, dst: dst_i, flags: in_flags, flag_we: flag_we_i};

  // flag_we sits in bit 0 of the packed entry.
  skid_buffer #(
    .WIDTH   ($bits(entry_t)),
    .MARK_BIT(0)
  ) u_skid_buffer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_entry),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (head_entry),
    .skid_valid_o(skid_valid),
    .main_mark_o (head_flag_we),
    .skid_mark_o (skid_flag_we)
  );

  assign r_o       = head_entry.r;
  assign dst_o     = head_entry.dst;
  assign flags_o   = head_entry.flags;
  assign flag_we_o = head_entry.flag_we;

  // Carry commits at writeback so it stays architecturally ordered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      carry_reg <= 1'b0;
    end else if (out_valid_o && out_ready_i && flag_we_o) begin
      carry_reg <= flags_o[FLAG_CF];
    end
  end

  assign carry_o = carry_reg;

  // Drops on the same edge the carry register updates, so issue logic
  // never sees a window where neither reflects the pending write.
  assign pending_flag_o = (out_valid_o && head_flag_we) || (skid_valid && skid_flag_we);

endmodule

// File: tb/tb_shift_result_stage.sv
module tb_shift_result_stage;

  localparam int W = 16;
  localparam int D = 3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] r_i;
  logic         cf_i;
  logic         a_msb_i;
  logic         flag_we_i;
  logic [D-1:0] dst_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] r_o;
  logic [D-1:0] dst_o;
  logic [3:0]   flags_o;
  logic         flag_we_o;
  logic         carry_o;
  logic         pending_flag_o;

  always #5 clk_i = ~clk_i;

  shift_result_stage #(.WORD_WIDTH(W), .DST_WIDTH(D)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .r_i           (r_i),
    .cf_i          (cf_i),
    .a_msb_i       (a_msb_i),
    .flag_we_i     (flag_we_i),
    .dst_i         (dst_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .r_o           (r_o),
    .dst_o         (dst_o),
    .flags_o       (flags_o),
    .flag_we_o     (flag_we_o),
    .carry_o       (carry_o),
    .pending_flag_o(pending_flag_o)
  );

  // Reference model: an ordered list of entries awaiting writeback
  // (at most two) and the architectural carry bit.
  typedef struct {
    logic [W-1:0] r;
    logic [D-1:0] dst;
    logic [3:0]   flags;
    logic         fwe;
  } exp_t;

  exp_t q[$];
  logic carry_m;
  int   n_vec;
  int   n_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, check outputs, advance model.
  task automatic step(input logic iv, input logic [W-1:0] r, input logic cf,
                      input logic am, input logic fwe, input logic [D-1:0] dst,
                      input logic ordy);
    logic pend;
    logic xfer;
    logic acc;
    exp_t e;
    in_valid_i  = iv;
    r_i         = r;
    cf_i        = cf;
    a_msb_i     = am;
    flag_we_i   = fwe;
    dst_i       = dst;
    out_ready_i = ordy;
    #1;
    pend = 1'b0;
    foreach (q[k]) if (q[k].fwe) pend = 1'b1;
    check_val("out_valid", out_valid_o, q.size() > 0);
    check_val("in_ready", in_ready_o, q.size() < 2);
    check_val("pending", pending_flag_o, pend);
    check_val("carry", carry_o, carry_m);
    if (q.size() > 0) begin
      check_val("r", r_o, q[0].r);
      check_val("dst", dst_o, q[0].dst);
      check_val("flags", flags_o, q[0].flags);
      check_val("flag_we", flag_we_o, q[0].fwe);
    end
    xfer = (q.size() > 0) && ordy;
    acc  = iv && (q.size() < 2);
    if (xfer) begin
      $display("writeback r=%h dst=%0d flags=%b fwe=%b", q[0].r, q[0].dst, q[0].flags, q[0].fwe);
      if (q[0].fwe) carry_m = q[0].flags[0];
      void'(q.pop_front());
    end
    if (acc) begin
      e.r     = r;
      e.dst   = dst;
      e.fwe   = fwe;
      e.flags = {am ^ r[W-1], r[W-1], (r == 0), cf};
      q.push_back(e);
    end
    @(negedge clk_i);
  endtask

  task automatic rand_step(input int ready_pct);
    logic [W-1:0] r;
    r = W'($urandom);
    if ($urandom_range(0, 7) == 0) r = '0;
    step(1'($urandom), r, 1'($urandom), 1'($urandom), 1'($urandom),
         D'($urandom), ($urandom_range(0, 99) < ready_pct));
  endtask

  initial begin
    logic [W-1:0] v;
    n_vec       = 0;
    n_err       = 0;
    carry_m     = 1'b0;
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    r_i         = '0;
    cf_i        = 1'b0;
    a_msb_i     = 1'b0;
    flag_we_i   = 1'b0;
    dst_i       = '0;
    out_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state
    check_val("rst_out_valid", out_valid_o, 1'b0);
    check_val("rst_in_ready", in_ready_o, 1'b1);
    check_val("rst_carry", carry_o, 1'b0);
    check_val("rst_pending", pending_flag_o, 1'b0);
    check_val("rst_r", r_o, 0);

    // Flags: zero result with carry and overflow
    step(1, 16'h0000, 1, 1, 1, 3'd5, 0);
    check_val("flags_1011", flags_o, 4'b1011);
    step(0, 16'hdead, 0, 0, 0, 3'd0, 1);
    step(0, 16'hbeef, 0, 0, 0, 3'd0, 0);
    check_val("carry_set", carry_o, 1'b1);

    // Carry hold: clear carry, then a non-flag entry with cf=1
    step(1, 16'h0001, 0, 0, 1, 3'd1, 1);
    step(0, 16'h0000, 0, 0, 0, 3'd0, 1);
    step(1, 16'h8000, 1, 0, 0, 3'd2, 1);
    step(0, 16'h0000, 0, 0, 0, 3'd0, 1);
    step(0, 16'h0000, 0, 0, 0, 3'd0, 1);
    check_val("carry_hold", carry_o, 1'b0);

    // Pending: flag entry then non-flag entry, held
    step(1, 16'h4000, 1, 0, 1, 3'd3, 0);
    step(1, 16'h0040, 0, 0, 0, 3'd4, 0);
    step(0, 16'h0000, 0, 0, 0, 3'd0, 0);
    check_val("pending_held", pending_flag_o, 1'b1);
    step(0, 16'h0000, 0, 0, 0, 3'd0, 1);
    check_val("pending_clear", pending_flag_o, 1'b0);
    check_val("carry_update", carry_o, 1'b1);
    step(0, 16'h0000, 0, 0, 0, 3'd0, 1);

    // Backpressure
    step(1, 16'h1111, 0, 0, 0, 3'd1, 0);
    step(1, 16'h2222, 0, 0, 0, 3'd2, 0);
    step(1, 16'h3333, 0, 0, 0, 3'd3, 0);
    check_val("bp_in_ready", in_ready_o, 1'b0);
    check_val("bp_head", r_o, 16'h1111);
    step(0, 16'h0000, 0, 0, 0, 3'd0, 1);
    step(0, 16'h0000, 0, 0, 0, 3'd0, 1);
    step(0, 16'h0000, 0, 0, 0, 3'd0, 1);

    // Streaming, 1 per cycle
    for (int i = 0; i < 8; i++) begin
      v = W'(1) << i;
      step(1, v, 0, 0, 0, D'(i), 1);
    end
    step(0, 16'h0000, 0, 0, 0, 3'd0, 1);
    step(0, 16'h0000, 0, 0, 0, 3'd0, 1);

    // Random traffic with varied backpressure
    for (int i = 0; i < 400; i++) rand_step((i < 200) ? 50 : 85);

    // Reset mid-stream with two flag-writing entries held
    step(1, 16'h0000, 1, 0, 1, 3'd6, 0);
    step(1, 16'h0000, 1, 0, 1, 3'd7, 0);
    step(1, 16'h5555, 1, 0, 1, 3'd7, 0);
    rst_i = 1'b1;
    #1;
    check_val("mid_rst_out_valid", out_valid_o, 1'b0);
    check_val("mid_rst_in_ready", in_ready_o, 1'b1);
    check_val("mid_rst_carry", carry_o, 1'b0);
    check_val("mid_rst_pending", pending_flag_o, 1'b0);
    q.delete();
    carry_m = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    step(0, 16'h0000, 0, 0, 0, 3'd0, 1);
    for (int i = 0; i < 60; i++) rand_step(70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_result_stage.md
Name: shift_result_stage

Overview:
- Pipeline stage directly downstream of the ALU left-shift unit.
- Captures the shifted result and shift carry-out, derives the flags, and buffers the result in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Owns the architectural carry register whose output feeds the shift unit's carry input.
- Exports a pending-flag-write indication so issue logic can stall carry-dependent shifts.

Parameters:
- WORD_WIDTH, 16, datapath width; must be ≥ 2.
- DST_WIDTH, 3, destination register tag width.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  upstream result valid.
- in_ready_o  out  1  stage can accept a result this cycle.
- r_i  in  WORD_WIDTH  shifted result from the shift unit.
- cf_i  in  1  carry-out from the shift unit.
- a_msb_i  in  1  MSB of the unshifted operand, used for overflow.
- flag_we_i  in  1  this operation updates the flags and carry register.
- dst_i  in  DST_WIDTH  destination tag, passed through.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream (writeback) accepts the head entry.
- r_o  out  WORD_WIDTH  head result.
- dst_o  out  DST_WIDTH  head destination tag.
- flags_o  out  4  head flags {of,sf,zf,cf}.
- flag_we_o  out  1  head flag-write enable.
- carry_o  out  1  architectural carry register; drives the shift unit's carry input.
- pending_flag_o  out  1  any buffered entry has flag_we set.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: all valids 0, all data/tag/flag registers 0, carry_o 0, in_ready_o 1, out_valid_o 0, pending_flag_o 0.
- Reset mid-operation: buffered entries are discarded and not written back; the carry register clears.
- Flag derivation, at input, registered with the entry:
  - zf = (r_i == 0)
  - sf = r_i[WORD_WIDTH-1]
  - of = a_msb_i ^ r_i[WORD_WIDTH-1]
  - cf = cf_i
- Input accept when in_valid_i & in_ready_o. Output transfer when out_valid_o & out_ready_i.
- Storage: main register (head, drives the outputs) plus skid register.
- in_ready_o = !skid_valid. It comes only from registered state, with no combinational path from out_ready_i.
- Buffer transitions:
  - Empty + accept → entry to main. out_valid_o rises next cycle (latency 1).
  - Main valid + accept + transfer → new entry replaces main.
  - Main valid + accept + no transfer → entry to skid, so in_ready_o falls next cycle.
  - Skid valid + transfer → skid moves to main, skid empties.
  - Skid valid + no transfer → hold everything.
- Ordering: strict FIFO, no drops, no duplicates. Sustained throughput is 1 per cycle when out_ready_i is held high.
- Head stability: while out_valid_o & !out_ready_i, all head outputs are held stable.
- Carry register: on output transfer with flag_we_o=1, carry_o takes flags_o[0]; the new value is visible the cycle after the transfer. On a transfer with flag_we_o=0, carry_o is unchanged.
- pending_flag_o = (main_valid & main.flag_we) | (skid_valid & skid.flag_we). Combinational from registers. It drops in the same cycle the last flag-writing entry transfers, because the carry update lands on that edge.
- Simultaneous accept and transfer when full: this cannot happen, since in_ready_o=0 while skid is valid.
- Data inputs are don't-care when in_valid_i=0 and must not affect state.

Decomposition:
- Shared ALU package:
  - alu_flags_t packed struct {of,sf,zf,cf}.
  - Flag index constants FLAG_CF=0, FLAG_ZF=1, FLAG_SF=2, FLAG_OF=3.
  - Entry struct type {r, dst, flags, flag_we}, parameterised by width through the package parameters.
- Sub-module skid_buffer #(WIDTH): a generic 2-entry valid/ready buffer on a flat vector. shift_result_stage packs the entry struct into it and keeps the flag derivation, carry register and pending logic.

Test Plan:
- Reset/idle: rst_i pulsed mid-stream with 2 entries held → next cycle out_valid_o=0, in_ready_o=1, carry_o=0, pending_flag_o=0.
- Flags: W=16; r_i=0x0000, cf_i=1, a_msb_i=1, flag_we_i=1 → one cycle later flags_o=4'b1011 (of=1, sf=0, zf=1, cf=1). After transfer, carry_o=1 on the following cycle.
- Backpressure: out_ready_i=0, send 0x1111 then 0x2222 → in_ready_o=0 after the second accept, head holds 0x1111. Raise out_ready_i → 0x1111 then 0x2222 emerge in order, in_ready_o returns to 1.
- Streaming: out_ready_i=1, 8 back-to-back inputs 0x0001..0x0080 → 8 outputs on consecutive cycles, same order, in_ready_o constantly 1.
- Carry hold: an entry with flag_we_i=0 and cf_i=1 transfers while carry_o=0 → carry_o stays 0 and pending_flag_o stays 0 throughout.
- Pending: flag_we entry followed by a non-flag entry, out_ready_i=0 → pending_flag_o=1 while both are held. It clears on the edge the flag entry transfers, and carry_o updates on that same edge.
